// File: rtl/lane_position_ctrl.sv
// Player-lane controller: debounced left/right keys become one-lane moves over
// NUM_LANES lanes, each sequenced through a DrawReq/DrawDone handshake with a one-deep move buffer.

module lane_position_ctrl_deb #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q, lvl_q, lvl_d1_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      lvl_q    <= 1'b0;
      lvl_d1_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      lvl_d1_q <= lvl_q;
      if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        lvl_q <= ~lvl_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // One pulse per debounced rising edge; a held key never re-fires.
  assign press_o = lvl_q & ~lvl_d1_q;
endmodule

module lane_position_ctrl #(
  parameter int NUM_LANES       = 4,
  parameter int POS_W           = 2,
  parameter int START_POS       = 0,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WRAP            = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             LeftIn,
  input  logic             RightIn,
  input  logic             DrawDone,
  output logic [POS_W-1:0] CurrPos,
  output logic [POS_W-1:0] PrevPos,
  output logic             DrawReq,
  output logic             Settled,
  output logic             Overrun
);
  localparam logic [POS_W-1:0] LAST  = POS_W'(NUM_LANES - 1);
  localparam logic [POS_W-1:0] START = POS_W'(START_POS);

  typedef enum logic {IDLE, DRAW} state_t;

  logic [1:0] raw, press;  // [0] left, [1] right
  assign raw = {RightIn, LeftIn};

  for (genvar k = 0; k < 2; k++) begin : g_key
    lane_position_ctrl_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .Clock  (Clock),
      .Reset  (Reset),
      .raw_i  (raw[k]),
      .press_o(press[k])
    );
  end

  logic ev_vld, ev_right;
  assign ev_vld   = press[0] ^ press[1];
  assign ev_right = press[1];

  state_t           state_q;
  logic             pend_vld_q, pend_right_q;
  logic [POS_W-1:0] curr_q, prev_q;
  logic             req_q, settled_q, ovr_q;

  // Buffered move wins over a fresh press; legality is judged against the lane at issue time.
  logic             mv_vld, mv_right, mv_legal;
  logic [POS_W-1:0] mv_tgt;
  always_comb begin
    mv_vld   = pend_vld_q | ev_vld;
    mv_right = pend_vld_q ? pend_right_q : ev_right;
    mv_tgt   = '0;
    mv_legal = 1'b1;
    if (mv_right) begin
      if (curr_q == LAST) begin
        mv_tgt   = '0;
        mv_legal = (WRAP != 0);
      end else begin
        mv_tgt = curr_q + POS_W'(1);
      end
    end else begin
      if (curr_q == '0) begin
        mv_tgt   = LAST;
        mv_legal = (WRAP != 0);
      end else begin
        mv_tgt = curr_q - POS_W'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= IDLE;
      pend_vld_q   <= 1'b0;
      pend_right_q <= 1'b0;
      curr_q       <= START;
      prev_q       <= START;
      req_q        <= 1'b0;
      settled_q    <= 1'b1;
      ovr_q        <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Serving the slot frees it; a same-cycle press refills it.
          if (pend_vld_q) begin
            pend_vld_q <= ev_vld;
            if (ev_vld) pend_right_q <= ev_right;
          end
          if (mv_vld && mv_legal) begin
            prev_q    <= curr_q;
            curr_q    <= mv_tgt;
            req_q     <= 1'b1;
            settled_q <= 1'b0;
            state_q   <= DRAW;
          end
        end
        DRAW: begin
          if (ev_vld) begin
            if (!pend_vld_q) begin
              pend_vld_q   <= 1'b1;
              pend_right_q <= ev_right;
            end else begin
              ovr_q <= 1'b1;
            end
          end
          if (DrawDone) begin
            req_q     <= 1'b0;
            settled_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CurrPos = curr_q;
  assign PrevPos = prev_q;
  assign DrawReq = req_q;
  assign Settled = settled_q;
  assign Overrun = ovr_q;
endmodule
